// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_if
//  Description : Byte-link and program-memory write-port bundle for
//                prog_loader. The master side feeds bytes and observes the
//                memory write port and load status; the slave is the loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 8
);
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  cpu_hold;
   logic                  done;
   logic                  err;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
   );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : TRISC0 program-memory loader. Receives a framed byte stream
//                (A5, N, N x {hi,lo}, optional checksum), writes the words to
//                consecutive program-memory addresses from 0 and holds the
//                CPU in reset while a load is in progress.
//  Option      : LOADER_CSUM_EN - expect a mod-256 checksum byte after the
//                last word; a mismatch ends the load with err set.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
   parameter int DATA_WIDTH = 12,   // 9..16
   parameter int ADDR_WIDTH = 8     // 1..8
) (
   input  wire logic    clk,
   input  wire logic    reset,      // asynchronous, active low
   prog_loader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_HI    = 3'd2,
      S_LO    = 3'd3,
      S_WRITE = 3'd4,
      S_CSUM  = 3'd5,
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } state_e;

   localparam logic [7:0] HEADER = 8'hA5;

   state_e                  state_q,    state_d;
   logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
   logic [8:0]              count_q,    count_d;     // 1..256 words left
   logic [DATA_WIDTH-9:0]   hi_q,       hi_d;        // only the bits that reach wr_data
   logic                    wr_en_q,    wr_en_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q,  wr_addr_d;
   logic [DATA_WIDTH-1:0]   wr_data_q,  wr_data_d;
   logic                    hold_q,     hold_d;
   logic                    done_q,     done_d;
   logic                    err_q,      err_d;
`ifdef LOADER_CSUM_EN
   logic [7:0]              csum_q,     csum_d;
`endif

   logic rx_ready;
   logic fire;

   // Ready is a pure state decode so rx_valid never loops back into it.
   assign rx_ready = (state_q != S_WRITE);
   assign fire     = bus.rx_valid && rx_ready;

   assign bus.rx_ready = rx_ready;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.cpu_hold = hold_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;

   // State and datapath registers; reset aborts any load in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         count_q   <= '0;
         hi_q      <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         hold_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef LOADER_CSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         hold_q    <= hold_d;
         done_q    <= done_d;
         err_q     <= err_d;
`ifdef LOADER_CSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   // Frame parser: next state plus the next value of every registered output.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      count_d   = count_q;
      hi_d      = hi_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      hold_d    = hold_q;
      done_d    = done_q;
      err_d     = err_q;
`ifdef LOADER_CSUM_EN
      csum_d    = csum_q;
`endif

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (fire && bus.rx_data == HEADER) begin
               state_d = S_LEN;
               hold_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
               addr_d  = '0;
`ifdef LOADER_CSUM_EN
               csum_d  = '0;
`endif
            end
         end
         S_LEN: begin
            if (fire) begin
               // A length byte of zero encodes a full 256-word image.
               count_d = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
               state_d = S_HI;
            end
         end
         S_HI: begin
            if (fire) begin
               hi_d    = bus.rx_data[DATA_WIDTH-9:0];
`ifdef LOADER_CSUM_EN
               csum_d  = csum_q + bus.rx_data;
`endif
               state_d = S_LO;
            end
         end
         S_LO: begin
            if (fire) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = {hi_q, bus.rx_data};
`ifdef LOADER_CSUM_EN
               csum_d    = csum_q + bus.rx_data;
`endif
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            count_d = count_q - 9'd1;
            if (count_q == 9'd1) begin
`ifdef LOADER_CSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_DONE;
               hold_d  = 1'b0;
               done_d  = 1'b1;
`endif
            end else begin
               state_d = S_HI;
            end
         end
`ifdef LOADER_CSUM_EN
         S_CSUM: begin
            if (fire) begin
               hold_d = 1'b0;
               if (bus.rx_data == csum_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Randomized scoreboard bench for prog_loader. Frames are
//                built from word lists; the expected memory writes are
//                queued as each word is issued and a monitor checks every
//                wr_en pulse against the queue.
//  Option      : LOADER_CSUM_EN - must match the build of the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
   localparam int DW = 12;
   localparam int AW = 8;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   prog_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [15:0] words[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (reset && bus.wr_en) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                     bus.wr_addr, bus.wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.wr_addr), 32'(mon_e.a));
            chk("wr_data", 32'(bus.wr_data), 32'(mon_e.d));
            chk("rx_ready_in_write", 32'(bus.rx_ready), 32'd0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int   n;
      logic rdy;
      repeat (gap) begin
         @(negedge clk);
         bus.rx_valid = 1'b0;
      end
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      n = 0;
      forever begin
         rdy = bus.rx_ready;
         @(posedge clk);
         if (rdy) break;
         n++;
         if (n > 20) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_accept_timeout: got no rx_ready for byte %0h expected within 20 cycles", b);
            break;
         end
         @(negedge clk);
      end
   endtask

   function automatic int gap_of(input int mode);
      if (mode == 1) return 1;
      if (mode == 2) return int'($urandom_range(0, 2));
      return 0;
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
      chk({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
      chk({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
      chk({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
      chk({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd0);
      chk({tag, "_done"},     32'(bus.done),     32'd0);
      chk({tag, "_err"},      32'(bus.err),      32'd0);
   endtask

   // Send one complete frame made of the words in 'words'.
   task automatic run_frame(input logic [7:0] nbyte, input bit bad, input int mode);
      int sum;
      sum = 0;
      send_byte(8'hA5, gap_of(mode));
      @(negedge clk);
      bus.rx_valid = 1'b0;
      chk("hold_after_header", 32'(bus.cpu_hold), 32'd1);
      chk("done_cleared",      32'(bus.done),     32'd0);
      chk("err_cleared",       32'(bus.err),      32'd0);
      send_byte(nbyte, gap_of(mode));
      for (int i = 0; i < words.size(); i++) begin
         sum = (sum + int'(words[i][15:8]) + int'(words[i][7:0])) % 256;
         send_byte(words[i][15:8], gap_of(mode));
         exp_q.push_back('{a: AW'(i % (1 << AW)), d: DW'(int'(words[i]) % (1 << DW))});
         send_byte(words[i][7:0], gap_of(mode));
      end
`ifdef LOADER_CSUM_EN
      send_byte(bad ? 8'(sum ^ 1) : 8'(sum), gap_of(mode));
      @(negedge clk);
      bus.rx_valid = 1'b0;
      chk("end_done",     32'(bus.done),     bad ? 32'd0 : 32'd1);
      chk("end_err",      32'(bus.err),      bad ? 32'd1 : 32'd0);
      chk("end_cpu_hold", 32'(bus.cpu_hold), 32'd0);
`else
      @(negedge clk);
      bus.rx_valid = 1'b0;
      chk("hold_in_last_write", 32'(bus.cpu_hold), 32'd1);
      chk("done_in_last_write", 32'(bus.done),     32'd0);
      @(negedge clk);
      chk("end_done",     32'(bus.done),     32'd1);
      chk("end_err",      32'(bus.err),      32'd0);
      chk("end_cpu_hold", 32'(bus.cpu_hold), 32'd0);
`endif
      chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic random_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++)
         words.push_back({(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom)), 8'($urandom)});
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b1;

      // Basic two-word load.
      words = '{16'h0123, 16'h0456};
      run_frame(8'd2, 1'b0, 0);

      // Same frame with a corrupted checksum (a plain reload without it).
      run_frame(8'd2, 1'b1, 0);

      // Leading garbage is discarded; unused high bits are dropped.
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h13, 0);
      words = '{16'hFABC};
      run_frame(8'd1, 1'b0, 0);

      // rx_valid toggling every other cycle.
      random_words(3);
      run_frame(8'd3, 1'b0, 1);

      // Reset after the second word of a four-word frame.
      random_words(2);
      send_byte(8'hA5, 0);
      send_byte(8'd4, 0);
      for (int i = 0; i < 2; i++) begin
         send_byte(words[i][15:8], 0);
         exp_q.push_back('{a: AW'(i), d: DW'(int'(words[i]) % (1 << DW))});
         send_byte(words[i][7:0], 0);
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
      check_reset_vals("midload_reset");
      chk("midload_writes_outstanding", 32'(exp_q.size()), 32'd0);
      bus.rx_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      random_words(4);
      run_frame(8'd4, 1'b0, 0);

      // Randomized frames with random gaps and random checksum faults.
      for (int f = 0; f < 8; f++) begin
         int n;
         n = int'($urandom_range(1, 6));
         random_words(n);
         run_frame(8'(n), bit'($urandom_range(0, 1)), 2);
      end

      // Length byte 0 means a full 256-word image.
      random_words(256);
      run_frame(8'd0, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
